// File: rtl/center_tracker_pkg.sv
// rtl/center_tracker_pkg.sv - shared constants and state encoding for center_tracker
package center_pkg;

    localparam int X_W = 11;    // pixel column counter width
    localparam int Y_W = 10;    // pixel row counter width
    localparam int C_W = 10;    // center coordinate width

    // Default screen center, used as the reset position of the filter.
    localparam logic [C_W-1:0] X_DEF = 10'd512;
    localparam logic [C_W-1:0] Y_DEF = 10'd384;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_SETTLE     = 2'd1,
        ST_SAMPLE     = 2'd2,
        ST_UPDATE     = 2'd3
    } state_e;

endpackage

// File: rtl/center_tracker_if.sv
// rtl/center_tracker_if.sv - raster/center inputs and filtered position outputs
// Ports: x, y        pixel counters (master -> slave)
//        xCenter, yCenter, found   center-of-mass result (master -> slave)
//        xSmooth, ySmooth, tracking, lost, frameStrobe   filtered result (slave -> master)
interface center_tracker_if;
    import center_pkg::*;

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] xCenter;
    logic [C_W-1:0] yCenter;
    logic           found;
    logic [C_W-1:0] xSmooth;
    logic [C_W-1:0] ySmooth;
    logic           tracking;
    logic           lost;
    logic           frameStrobe;

    modport master (
        output x, y, xCenter, yCenter, found,
        input  xSmooth, ySmooth, tracking, lost, frameStrobe
    );

    modport slave (
        input  x, y, xCenter, yCenter, found,
        output xSmooth, ySmooth, tracking, lost, frameStrobe
    );

endinterface

// File: rtl/center_tracker_ema_axis.sv
// rtl/center_tracker_ema_axis.sv - one axis of the smoothing filter with jump detection
// Ports: clk, reset   clock and synchronous active-high reset
//        sample       latched center for this axis
//        init_en      load accumulator and output directly from sample
//        step_en      apply one EMA step
//        smooth       filtered position
//        jump         |sample - smooth| exceeds JUMP_MAX
module ema_axis
    import center_pkg::*;
#(
    parameter int             SHIFT     = 2,
    parameter logic [C_W-1:0] JUMP_MAX  = 10'd200,
    parameter logic [C_W-1:0] RESET_VAL = 10'd512
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [C_W-1:0] sample,
    input  logic           init_en,
    input  logic           step_en,
    output logic [C_W-1:0] smooth,
    output logic           jump
);

    localparam int AW = C_W + SHIFT;

    logic [AW-1:0]  acc_q, acc_d;
    logic [C_W-1:0] smooth_q, smooth_d;
    logic [AW:0]    sum;
    logic [C_W:0]   diff;
    logic [C_W:0]   mag;

    always_comb begin
        // Extra top bit covers the transient before subtracting acc>>SHIFT;
        // the settled result always fits back into AW bits.
        sum  = {1'b0, acc_q}
             + {{(AW + 1 - C_W){1'b0}}, sample}
             - {1'b0, (acc_q >> SHIFT)};

        // Two's-complement 11-bit difference, then magnitude.
        diff = {1'b0, sample} - {1'b0, smooth_q};
        mag  = diff[C_W] ? (~diff + 1'b1) : diff;
        jump = mag > {1'b0, JUMP_MAX};

        acc_d    = acc_q;
        smooth_d = smooth_q;
        if (init_en) begin
            acc_d    = AW'(sample) << SHIFT;
            smooth_d = sample;
        end else if (step_en) begin
            acc_d    = sum[AW-1:0];
            smooth_d = sum[SHIFT +: C_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= AW'(RESET_VAL) << SHIFT;
            smooth_q <= RESET_VAL;
        end else begin
            acc_q    <= acc_d;
            smooth_q <= smooth_d;
        end
    end

    assign smooth = smooth_q;

endmodule

// File: rtl/center_tracker.sv
// rtl/center_tracker.sv - per-frame center sampler with outlier rejection, EMA and loss detect
// Ports: clk, reset   clock and synchronous active-high reset
//        bus (slave)  pixel counters and center inputs; smoothed position,
//                     tracking/lost flags and frameStrobe outputs
module center_tracker
    import center_pkg::*;
#(
    parameter int             SETTLE      = 40,
    parameter int             SHIFT       = 2,
    parameter int             LOST_FRAMES = 3,
    parameter logic [C_W-1:0] JUMP_MAX    = 10'd200
) (
    input  logic             clk,
    input  logic             reset,
    center_tracker_if.slave  bus
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MC_W  = $clog2(LOST_FRAMES + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_origin_q, prev_origin_d;
    logic [C_W-1:0]   xs_q, xs_d;
    logic [C_W-1:0]   ys_q, ys_d;
    logic             found_s_q, found_s_d;
    logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic             tracking_q, tracking_d;
    logic             lost_q, lost_d;
    logic             strobe_q, strobe_d;

    logic             origin;
    logic             frame_start;
    logic             miss;
    logic             init_en;
    logic             step_en;
    logic             jump_x, jump_y;
    logic [C_W-1:0]   x_smooth, y_smooth;
    logic [MC_W-1:0]  mc_next;

    always_comb begin
        origin        = (bus.x == '0) && (bus.y == '0);
        // Only the first cycle of origin starts a frame, however long it is held.
        frame_start   = origin && !prev_origin_q;
        prev_origin_d = origin;

        state_d    = state_q;
        cnt_d      = cnt_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        found_s_d  = found_s_q;
        miss_cnt_d = miss_cnt_q;
        tracking_d = tracking_q;
        lost_d     = lost_q;
        strobe_d   = 1'b0;
        init_en    = 1'b0;
        step_en    = 1'b0;
        mc_next    = miss_cnt_q;

        // Jump rejection only applies once a filtered position exists.
        miss = !found_s_q || (tracking_q && (jump_x || jump_y));

        case (state_q)
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (frame_start) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                xs_d      = bus.xCenter;
                ys_d      = bus.yCenter;
                found_s_d = bus.found;
                state_d   = ST_UPDATE;
            end
            ST_UPDATE: begin
                strobe_d = 1'b1;
                state_d  = ST_WAIT_FRAME;
                if (miss) begin
                    if (miss_cnt_q != MC_W'(LOST_FRAMES)) begin
                        mc_next = miss_cnt_q + 1'b1;
                    end
                    miss_cnt_d = mc_next;
                    if (mc_next == MC_W'(LOST_FRAMES)) begin
                        lost_d     = 1'b1;
                        tracking_d = 1'b0;
                    end
                end else begin
                    init_en    = !tracking_q;
                    step_en    = tracking_q;
                    tracking_d = 1'b1;
                    lost_d     = 1'b0;
                    miss_cnt_d = '0;
                end
            end
            default: state_d = ST_WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT_FRAME;
            cnt_q         <= '0;
            prev_origin_q <= 1'b0;
            xs_q          <= '0;
            ys_q          <= '0;
            found_s_q     <= 1'b0;
            miss_cnt_q    <= '0;
            tracking_q    <= 1'b0;
            lost_q        <= 1'b1;
            strobe_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_origin_q <= prev_origin_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            found_s_q     <= found_s_d;
            miss_cnt_q    <= miss_cnt_d;
            tracking_q    <= tracking_d;
            lost_q        <= lost_d;
            strobe_q      <= strobe_d;
        end
    end

    ema_axis #(.SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX), .RESET_VAL(X_DEF)) u_ema_x (
        .clk     (clk),
        .reset   (reset),
        .sample  (xs_q),
        .init_en (init_en),
        .step_en (step_en),
        .smooth  (x_smooth),
        .jump    (jump_x)
    );

    ema_axis #(.SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX), .RESET_VAL(Y_DEF)) u_ema_y (
        .clk     (clk),
        .reset   (reset),
        .sample  (ys_q),
        .init_en (init_en),
        .step_en (step_en),
        .smooth  (y_smooth),
        .jump    (jump_y)
    );

    assign bus.xSmooth     = x_smooth;
    assign bus.ySmooth     = y_smooth;
    assign bus.tracking    = tracking_q;
    assign bus.lost        = lost_q;
    assign bus.frameStrobe = strobe_q;

endmodule

// File: tb/tb_center_tracker.sv
// tb/tb_center_tracker.sv - directed self-checking bench for center_tracker
module tb_center_tracker;

    localparam int SETTLE      = 40;
    localparam int SHIFT       = 2;
    localparam int LOST_FRAMES = 3;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   lat;
    int   cnt;

    center_tracker_if bus();

    center_tracker #(
        .SETTLE      (SETTLE),
        .SHIFT       (SHIFT),
        .LOST_FRAMES (LOST_FRAMES),
        .JUMP_MAX    (10'd200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_strobes(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.frameStrobe) seen++;
        end
    endtask

    // Raise origin, hold it for 'hold' sampling edges, and return the number
    // of edges after the frame-start edge until frameStrobe is seen (-1 if never).
    task automatic run_frame(input logic [9:0] xc, input logic [9:0] yc,
                             input logic fnd, input int hold, output int l);
        @(negedge clk);
        bus.xCenter = xc;
        bus.yCenter = yc;
        bus.found   = fnd;
        bus.x       = '0;
        bus.y       = '0;
        l = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (n + 1 >= hold) begin
                bus.x = 11'd5;
                bus.y = 10'd5;
            end
            if (bus.frameStrobe) begin
                l = n;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string tag, input int xe, input int ye,
                             input int te, input int le);
        check({tag, "_x"}, int'(bus.xSmooth), xe);
        check({tag, "_y"}, int'(bus.ySmooth), ye);
        check({tag, "_tracking"}, int'(bus.tracking), te);
        check({tag, "_lost"}, int'(bus.lost), le);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        bus.x       = 11'd5;
        bus.y       = 10'd5;
        bus.xCenter = '0;
        bus.yCenter = '0;
        bus.found   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state and no strobe without a frame start
        check_pos("reset", 512, 384, 0, 1);
        check("reset_strobe", int'(bus.frameStrobe), 0);
        idle_strobes(60, cnt);
        check("idle_no_strobe", cnt, 0);

        // First frame initialises directly from the sample
        run_frame(10'd300, 10'd200, 1'b1, 1, lat);
        check("first_latency", lat, SETTLE + 2);
        check("strobe_one_cycle", int'(bus.frameStrobe), 0);
        check_pos("first", 300, 200, 1, 0);

        // Second frame start during SETTLE restarts the wait
        @(negedge clk);
        bus.x = '0;
        bus.y = '0;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 0 || n == 10) begin
                bus.x = 11'd5;
                bus.y = 10'd5;
            end else if (n == 9) begin
                bus.x = '0;
                bus.y = '0;
            end
            if (bus.frameStrobe) begin
                lat = n;
                break;
            end
        end
        check("restart_latency", lat, SETTLE + 12);
        @(posedge clk);
        #1;
        check_pos("restart", 300, 200, 1, 0);

        // Origin held 5 cycles counts once; EMA steps
        apply_reset();
        run_frame(10'd100, 10'd100, 1'b1, 5, lat);
        check("held_latency", lat, SETTLE + 2);
        idle_strobes(60, cnt);
        check("held_single_strobe", cnt, 0);
        check_pos("init100", 100, 100, 1, 0);
        run_frame(10'd200, 10'd100, 1'b1, 1, lat);
        check_pos("ema1", 125, 100, 1, 0);
        run_frame(10'd200, 10'd100, 1'b1, 1, lat);
        check_pos("ema2", 143, 100, 1, 0);

        // Jump rejection counts toward lost; reacquire after lost
        apply_reset();
        run_frame(10'd100, 10'd100, 1'b1, 1, lat);
        run_frame(10'd400, 10'd100, 1'b1, 1, lat);
        check_pos("jump1", 100, 100, 1, 0);
        run_frame(10'd400, 10'd100, 1'b1, 1, lat);
        check_pos("jump2", 100, 100, 1, 0);
        run_frame(10'd400, 10'd100, 1'b1, 1, lat);
        check_pos("jump3", 100, 100, 0, 1);
        run_frame(10'd400, 10'd100, 1'b1, 1, lat);
        check_pos("reacquire", 400, 100, 1, 0);

        // Empty frames below the threshold; a hit clears the miss count
        run_frame(10'd0, 10'd0, 1'b0, 1, lat);
        run_frame(10'd0, 10'd0, 1'b0, 1, lat);
        check_pos("empty2", 400, 100, 1, 0);
        run_frame(10'd400, 10'd100, 1'b1, 1, lat);
        check_pos("hit", 400, 100, 1, 0);
        run_frame(10'd0, 10'd0, 1'b0, 1, lat);
        run_frame(10'd0, 10'd0, 1'b0, 1, lat);
        check("empty4_latency", lat, SETTLE + 2);
        check_pos("empty4", 400, 100, 1, 0);

        // Reset during SETTLE: no strobe, reset values restored
        @(negedge clk);
        bus.xCenter = 10'd50;
        bus.yCenter = 10'd60;
        bus.found   = 1'b1;
        bus.x       = '0;
        bus.y       = '0;
        @(posedge clk);
        #1;
        bus.x = 11'd5;
        bus.y = 10'd5;
        repeat (10) @(posedge clk);
        apply_reset();
        #1;
        check_pos("mid_reset", 512, 384, 0, 1);
        idle_strobes(80, cnt);
        check("mid_reset_no_strobe", cnt, 0);
        check_pos("mid_reset_after", 512, 384, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
